// File: rtl/mc_cpu_pkg.sv
// ----------------------------------------------------------------------------
// mc_cpu_pkg
// Shared definitions for the multi-cycle control unit: FSM state encoding,
// opcode and ALU-function constants, PC source selects, the bundle of
// datapath strobes, and small decode helpers used by the control FSM.
// ----------------------------------------------------------------------------
package mc_cpu_pkg;

  // Width of the handshake wait counter; large enough for WAIT_MAX up to 255.
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [3:0] {
    S_IF,
    S_ID,
    S_AL,
    S_WB,
    S_BR,
    S_LS,
    S_MEM,
    S_LDWB,
    S_HALT
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU functions
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // PC source selects
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_MEM,
    CLS_JUMP,
    CLS_HALT,
    CLS_UNDEF
  } op_class_e;

  typedef struct packed {
    logic       r_type;
    logic       src_a;
    logic       src_b;
    logic       ext_sel;
    logic [2:0] alu_op;
  } alu_ctl_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       ir_wre;
    logic       pc_wre;
    logic [1:0] pc_src;
    logic       reg_wre;
    logic       reg_dst;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       db_data_src;
    logic       n_rd;
    logic       n_wr;
  } strobes_t;

  // Every strobe inactive; memory controls are active-low.
  localparam strobes_t STROBES_IDLE = '{
    imem_req:    1'b0,
    dmem_req:    1'b0,
    ir_wre:      1'b0,
    pc_wre:      1'b0,
    pc_src:      PC_SEQ,
    reg_wre:     1'b0,
    reg_dst:     1'b0,
    alu_src_a:   1'b0,
    alu_src_b:   1'b0,
    alu_op:      ALU_ADD,
    ext_sel:     1'b0,
    db_data_src: 1'b0,
    n_rd:        1'b1,
    n_wr:        1'b1
  };

  function automatic op_class_e op_class(logic [5:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_ADDIU, OP_ANDI, OP_AND,
      OP_ORI, OP_OR, OP_SLL, OP_SLTI:  return CLS_ALU;
      OP_BEQ, OP_BNE, OP_BLTZ:         return CLS_BRANCH;
      OP_SW, OP_LW:                    return CLS_MEM;
      OP_J:                            return CLS_JUMP;
      OP_HALT:                         return CLS_HALT;
      default:                         return CLS_UNDEF;
    endcase
  endfunction

  // ALU-stage controls for the arithmetic/logic opcodes.
  function automatic alu_ctl_t alu_decode(logic [5:0] opc);
    alu_ctl_t c;
    c = '{r_type: 1'b0, src_a: 1'b0, src_b: 1'b0, ext_sel: 1'b0, alu_op: ALU_ADD};
    case (opc)
      OP_ADD:   begin c.r_type = 1'b1; c.alu_op = ALU_ADD; end
      OP_SUB:   begin c.r_type = 1'b1; c.alu_op = ALU_SUB; end
      OP_AND:   begin c.r_type = 1'b1; c.alu_op = ALU_AND; end
      OP_OR:    begin c.r_type = 1'b1; c.alu_op = ALU_OR;  end
      OP_SLL:   begin c.r_type = 1'b1; c.src_a = 1'b1; c.alu_op = ALU_SLL; end
      OP_ADDIU: begin c.src_b = 1'b1; c.ext_sel = 1'b1; c.alu_op = ALU_ADD; end
      OP_ANDI:  begin c.src_b = 1'b1; c.alu_op = ALU_AND; end
      OP_ORI:   begin c.src_b = 1'b1; c.alu_op = ALU_OR;  end
      OP_SLTI:  begin c.src_b = 1'b1; c.ext_sel = 1'b1; c.alu_op = ALU_SLT; end
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_unit_wait_timer.sv
// ----------------------------------------------------------------------------
// mc_wait_timer
// Counts consecutive cycles spent waiting on a memory handshake and flags the
// last permitted cycle. The owner decides whether ready beats timeout.
//
// Ports
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low reset
//   clr_i      force the count to zero (not waiting, or ready seen)
//   en_i       count this cycle
//   timeout_o  this is the WAIT_MAX-th waiting cycle
// ----------------------------------------------------------------------------
module mc_wait_timer
  import mc_cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(WAIT_MAX - 1);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  // NOTE: reset is synchronous here (sampled on the clock edge, not in the
  // sensitivity list), and state is updated with non-blocking assignments
  // so all flops see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_control_unit.sv
// ----------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back.
// Drives the datapath strobes combinationally from the registered state,
// the opcode, the ALU flags and the memory ready lines. Variable-latency
// instruction/data memories use req/ready handshakes guarded by a timeout.
//
// Ports
//   CLK, Reset         clock; synchronous active-low reset
//   Opcode             opcode from the external instruction register
//   zero, sign         ALU flags (registered in the datapath)
//   imem_ready/req     instruction fetch handshake
//   dmem_ready/req     data access handshake
//   IRWre, PCWre, PCSrc, RegWre, RegDst, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
//   DBDataSrc, nRD, nWR  datapath strobes
//   halted, bus_err, illegal  stop status
//   retired, cycles    debug counters (wrap)
// ----------------------------------------------------------------------------
module mc_control_unit
  import mc_cpu_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [OP_W-1:0]  Opcode,
  input  logic             zero,
  input  logic             sign,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWre,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             RegWre,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             ExtSel,
  output logic             DBDataSrc,
  output logic             nRD,
  output logic             nWR,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic             bus_err_q, bus_err_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic [5:0] opc;
  alu_ctl_t   alu_ctl;
  strobes_t   strb;
  logic       retire;
  logic       br_taken;
  logic       waiting;
  logic       mem_ready;
  logic       wait_timeout;

  assign opc     = 6'(Opcode);
  assign alu_ctl = alu_decode(opc);

  // Only fetch and data-memory states wait on a handshake.
  assign waiting   = (state_q == S_IF) || (state_q == S_MEM);
  assign mem_ready = (state_q == S_IF) ? imem_ready : dmem_ready;

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk_i     (CLK),
    .rst_ni    (Reset),
    .clr_i     (!waiting || mem_ready),
    .en_i      (waiting),
    .timeout_o (wait_timeout)
  );

  always_comb begin
    case (opc)
      OP_BEQ:  br_taken = zero;
      OP_BNE:  br_taken = !zero;
      OP_BLTZ: br_taken = sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    strb      = STROBES_IDLE;
    retire    = 1'b0;
    halted_d  = halted_q;
    bus_err_d = bus_err_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IF: begin
        strb.imem_req = 1'b1;
        // Ready on the final permitted cycle still completes the fetch.
        if (imem_ready) begin
          strb.ir_wre = 1'b1;
          state_d     = S_ID;
        end else if (wait_timeout) begin
          bus_err_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_ID: begin
        case (op_class(opc))
          CLS_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          CLS_JUMP: begin
            strb.pc_wre = 1'b1;
            strb.pc_src = PC_JUMP;
            retire      = 1'b1;
            state_d     = S_IF;
          end
          CLS_BRANCH: state_d = S_BR;
          CLS_MEM:    state_d = S_LS;
          CLS_ALU:    state_d = S_AL;
          default: begin
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end

      S_AL: begin
        strb.alu_src_a = alu_ctl.src_a;
        strb.alu_src_b = alu_ctl.src_b;
        strb.ext_sel   = alu_ctl.ext_sel;
        strb.alu_op    = alu_ctl.alu_op;
        state_d        = S_WB;
      end

      S_WB: begin
        strb.reg_wre = 1'b1;
        strb.reg_dst = alu_ctl.r_type;
        strb.pc_wre  = 1'b1;
        strb.pc_src  = PC_SEQ;
        retire       = 1'b1;
        state_d      = S_IF;
      end

      S_BR: begin
        // The ALU compares rs with rt (or zero for bltz) via subtraction.
        strb.alu_op  = ALU_SUB;
        strb.ext_sel = 1'b1;
        strb.pc_wre  = 1'b1;
        strb.pc_src  = br_taken ? PC_BRANCH : PC_SEQ;
        retire       = 1'b1;
        state_d      = S_IF;
      end

      S_LS: begin
        strb.alu_src_b = 1'b1;
        strb.ext_sel   = 1'b1;
        strb.alu_op    = ALU_ADD;
        state_d        = S_MEM;
      end

      S_MEM: begin
        strb.dmem_req = 1'b1;
        strb.n_rd     = (opc != OP_LW);
        strb.n_wr     = (opc != OP_SW);
        if (dmem_ready) begin
          if (opc == OP_SW) begin
            strb.pc_wre = 1'b1;
            retire      = 1'b1;
            state_d     = S_IF;
          end else begin
            state_d = S_LDWB;
          end
        end else if (wait_timeout) begin
          bus_err_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_LDWB: begin
        strb.reg_wre     = 1'b1;
        strb.db_data_src = 1'b1;
        strb.reg_dst     = 1'b0;
        strb.pc_wre      = 1'b1;
        retire           = 1'b1;
        state_d          = S_IF;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IF;
    endcase

    // Requests and strobes drop in the same cycle reset is asserted.
    if (!Reset) begin
      strb = STROBES_IDLE;
    end

    retired_d = retired_q + CNT_W'(retire);
    cycles_d  = (state_q != S_HALT) ? cycles_q + CNT_W'(1) : cycles_q;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= S_IF;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  assign imem_req  = strb.imem_req;
  assign dmem_req  = strb.dmem_req;
  assign IRWre     = strb.ir_wre;
  assign PCWre     = strb.pc_wre;
  assign PCSrc     = strb.pc_src;
  assign RegWre    = strb.reg_wre;
  assign RegDst    = strb.reg_dst;
  assign ALUSrcA   = strb.alu_src_a;
  assign ALUSrcB   = strb.alu_src_b;
  assign ALUOp     = strb.alu_op;
  assign ExtSel    = strb.ext_sel;
  assign DBDataSrc = strb.db_data_src;
  assign nRD       = strb.n_rd;
  assign nWR       = strb.n_wr;
  assign halted    = halted_q;
  assign bus_err   = bus_err_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// ----------------------------------------------------------------------------
// tb_mc_control_unit
// Self-checking bench for mc_control_unit (WAIT_MAX = 4). A transaction-level
// model turns each instruction plus its memory wait counts into the expected
// per-cycle strobe trace, retired/cycle deltas and halt outcome.
// ----------------------------------------------------------------------------
module tb_mc_control_unit;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 32;

  localparam logic [5:0] T_ADD   = 6'b000000;
  localparam logic [5:0] T_SUB   = 6'b000001;
  localparam logic [5:0] T_ADDIU = 6'b000010;
  localparam logic [5:0] T_ANDI  = 6'b010000;
  localparam logic [5:0] T_AND   = 6'b010001;
  localparam logic [5:0] T_ORI   = 6'b010010;
  localparam logic [5:0] T_OR    = 6'b010011;
  localparam logic [5:0] T_SLL   = 6'b011000;
  localparam logic [5:0] T_SLTI  = 6'b100111;
  localparam logic [5:0] T_SW    = 6'b110000;
  localparam logic [5:0] T_LW    = 6'b110001;
  localparam logic [5:0] T_BEQ   = 6'b110100;
  localparam logic [5:0] T_BNE   = 6'b110101;
  localparam logic [5:0] T_BLTZ  = 6'b110110;
  localparam logic [5:0] T_J     = 6'b111000;
  localparam logic [5:0] T_HALT  = 6'b111111;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       ir_wre;
    logic       pc_wre;
    logic [1:0] pc_src;
    logic       reg_wre;
    logic       reg_dst;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       db_data_src;
    logic       n_rd;
    logic       n_wr;
  } tb_strobes_t;

  typedef struct {
    tb_strobes_t exp;
    logic [5:0]  opc;
    logic        irdy;
    logic        drdy;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic       r_type;
    logic       src_a;
    logic       src_b;
    logic       ext;
    logic [2:0] alu_op;
  } alu_vec_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       s;
    logic [1:0] exp_pc_src;
  } br_vec_t;

  logic             CLK;
  logic             Reset;
  logic [5:0]       Opcode;
  logic             zero, sign, imem_ready, dmem_ready;
  logic             imem_req, dmem_req, IRWre, PCWre;
  logic [1:0]       PCSrc;
  logic             RegWre, RegDst, ALUSrcA, ALUSrcB;
  logic [2:0]       ALUOp;
  logic             ExtSel, DBDataSrc, nRD, nWR;
  logic             halted, bus_err, illegal;
  logic [CNT_W-1:0] retired, cycles;

  mc_control_unit #(
    .OP_W     (6),
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Opcode     (Opcode),
    .zero       (zero),
    .sign       (sign),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .IRWre      (IRWre),
    .PCWre      (PCWre),
    .PCSrc      (PCSrc),
    .RegWre     (RegWre),
    .RegDst     (RegDst),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ExtSel     (ExtSel),
    .DBDataSrc  (DBDataSrc),
    .nRD        (nRD),
    .nWR        (nWR),
    .halted     (halted),
    .bus_err    (bus_err),
    .illegal    (illegal),
    .retired    (retired),
    .cycles     (cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_retired;
  logic [31:0] exp_cycles;
  cyc_t        trace[$];
  int          exp_kind;   // 0 running, 1 halt, 2 bus error, 3 illegal
  int          exp_inc;
  logic [1:0]  last_pc_src;
  alu_vec_t    alu_tbl[9];
  br_vec_t     br_tbl[8];
  logic [5:0]  op_list[15];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic tb_strobes_t idle();
    tb_strobes_t s;
    s      = '0;
    s.n_rd = 1'b1;
    s.n_wr = 1'b1;
    return s;
  endfunction

  function automatic tb_strobes_t sample();
    tb_strobes_t s;
    s.imem_req    = imem_req;
    s.dmem_req    = dmem_req;
    s.ir_wre      = IRWre;
    s.pc_wre      = PCWre;
    s.pc_src      = PCSrc;
    s.reg_wre     = RegWre;
    s.reg_dst     = RegDst;
    s.alu_src_a   = ALUSrcA;
    s.alu_src_b   = ALUSrcB;
    s.alu_op      = ALUOp;
    s.ext_sel     = ExtSel;
    s.db_data_src = DBDataSrc;
    s.n_rd        = nRD;
    s.n_wr        = nWR;
    return s;
  endfunction

  function automatic int alu_idx(logic [5:0] op);
    for (int i = 0; i < 9; i++) if (alu_tbl[i].op == op) return i;
    return -1;
  endfunction

  function automatic bit is_defined(logic [5:0] op);
    return (alu_idx(op) >= 0) || op == T_SW || op == T_LW || op == T_BEQ ||
           op == T_BNE || op == T_BLTZ || op == T_J || op == T_HALT;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction.
  task automatic build_trace(logic [5:0] op, int iw, int dw, logic z, logic s);
    cyc_t c;
    int   nf, nm, ai;
    bit   taken;
    trace.delete();
    exp_kind = 0;
    exp_inc  = 0;
    nf = (iw < WAIT_MAX) ? iw + 1 : WAIT_MAX;
    for (int k = 0; k < nf; k++) begin
      c.exp          = idle();
      c.exp.imem_req = 1'b1;
      c.irdy         = (k == iw);
      c.exp.ir_wre   = c.irdy;
      c.opc          = 6'($urandom);  // IR not loaded yet
      c.drdy         = 1'($urandom);
      trace.push_back(c);
    end
    if (iw >= WAIT_MAX) begin
      exp_kind = 2;
      return;
    end
    c.exp  = idle();
    c.opc  = op;
    c.irdy = 1'($urandom);
    c.drdy = 1'($urandom);
    ai     = alu_idx(op);
    if (op == T_HALT) begin
      trace.push_back(c);
      exp_kind = 1;
    end else if (op == T_J) begin
      c.exp.pc_wre = 1'b1;
      c.exp.pc_src = 2'b10;
      trace.push_back(c);
      exp_inc = 1;
    end else if (op == T_BEQ || op == T_BNE || op == T_BLTZ) begin
      trace.push_back(c);
      taken = (op == T_BEQ && z) || (op == T_BNE && !z) || (op == T_BLTZ && s);
      c.exp         = idle();
      c.exp.alu_op  = 3'b001;
      c.exp.ext_sel = 1'b1;
      c.exp.pc_wre  = 1'b1;
      c.exp.pc_src  = taken ? 2'b01 : 2'b00;
      trace.push_back(c);
      exp_inc = 1;
    end else if (op == T_LW || op == T_SW) begin
      trace.push_back(c);
      c.exp           = idle();
      c.exp.alu_src_b = 1'b1;
      c.exp.ext_sel   = 1'b1;
      trace.push_back(c);
      nm = (dw < WAIT_MAX) ? dw + 1 : WAIT_MAX;
      for (int k = 0; k < nm; k++) begin
        c.exp          = idle();
        c.exp.dmem_req = 1'b1;
        c.exp.n_rd     = (op != T_LW);
        c.exp.n_wr     = (op != T_SW);
        c.drdy         = (k == dw);
        c.irdy         = 1'($urandom);
        c.exp.pc_wre   = (op == T_SW) && c.drdy;
        trace.push_back(c);
      end
      if (dw >= WAIT_MAX) begin
        exp_kind = 2;
        return;
      end
      if (op == T_LW) begin
        c.exp             = idle();
        c.exp.reg_wre     = 1'b1;
        c.exp.db_data_src = 1'b1;
        c.exp.pc_wre      = 1'b1;
        c.drdy            = 1'($urandom);
        trace.push_back(c);
      end
      exp_inc = 1;
    end else if (ai >= 0) begin
      trace.push_back(c);
      c.exp           = idle();
      c.exp.alu_src_a = alu_tbl[ai].src_a;
      c.exp.alu_src_b = alu_tbl[ai].src_b;
      c.exp.ext_sel   = alu_tbl[ai].ext;
      c.exp.alu_op    = alu_tbl[ai].alu_op;
      trace.push_back(c);
      c.exp         = idle();
      c.exp.reg_wre = 1'b1;
      c.exp.reg_dst = alu_tbl[ai].r_type;
      c.exp.pc_wre  = 1'b1;
      trace.push_back(c);
      exp_inc = 1;
    end else begin
      trace.push_back(c);
      exp_kind = 3;
    end
  endtask

  task automatic do_reset();
    Reset      = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    Opcode     = 6'($urandom);
    repeat (2) begin
      @(negedge CLK);
      check("reset strobes", 64'(sample()), 64'(idle()));
    end
    @(posedge CLK);
    #1;
    check("reset retired", 64'(retired), 64'd0);
    check("reset cycles", 64'(cycles), 64'd0);
    check("reset halted", 64'(halted), 64'd0);
    check("reset bus_err", 64'(bus_err), 64'd0);
    check("reset illegal", 64'(illegal), 64'd0);
    Reset       = 1'b1;
    exp_retired = '0;
    exp_cycles  = '0;
  endtask

  // Runs one instruction; stop_after > 0 drives only that many cycles.
  task automatic run_instr(logic [5:0] op, int iw, int dw, logic z, logic s,
                           int stop_after);
    build_trace(op, iw, dw, z, s);
    zero = z;
    sign = s;
    for (int k = 0; k < trace.size(); k++) begin
      if (stop_after != 0 && k >= stop_after) break;
      Opcode     = trace[k].opc;
      imem_ready = trace[k].irdy;
      dmem_ready = trace[k].drdy;
      @(negedge CLK);
      check($sformatf("strobes op=%b cyc=%0d", op, k), 64'(sample()),
            64'(trace[k].exp));
      last_pc_src = PCSrc;
      @(posedge CLK);
      #1;
    end
    if (stop_after != 0) return;
    exp_cycles  = exp_cycles + 32'(trace.size());
    exp_retired = exp_retired + 32'(exp_inc);
    check($sformatf("retired op=%b", op), 64'(retired), 64'(exp_retired));
    check($sformatf("cycles op=%b", op), 64'(cycles), 64'(exp_cycles));
    check($sformatf("halted op=%b", op), 64'(halted), 64'(exp_kind != 0));
    check($sformatf("bus_err op=%b", op), 64'(bus_err), 64'(exp_kind == 2));
    check($sformatf("illegal op=%b", op), 64'(illegal), 64'(exp_kind == 3));
    if (exp_kind != 0) begin
      repeat (3) begin
        Opcode     = 6'($urandom);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        @(negedge CLK);
        check("halt strobes", 64'(sample()), 64'(idle()));
        @(posedge CLK);
        #1;
      end
      check("halt cycles frozen", 64'(cycles), 64'(exp_cycles));
      check("halt retired held", 64'(retired), 64'(exp_retired));
      do_reset();
    end
  endtask

  initial begin
    alu_tbl[0] = '{T_ADD,   1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
    alu_tbl[1] = '{T_SUB,   1'b1, 1'b0, 1'b0, 1'b0, 3'b001};
    alu_tbl[2] = '{T_ADDIU, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000};
    alu_tbl[3] = '{T_ANDI,  1'b0, 1'b0, 1'b1, 1'b0, 3'b100};
    alu_tbl[4] = '{T_AND,   1'b1, 1'b0, 1'b0, 1'b0, 3'b100};
    alu_tbl[5] = '{T_ORI,   1'b0, 1'b0, 1'b1, 1'b0, 3'b011};
    alu_tbl[6] = '{T_OR,    1'b1, 1'b0, 1'b0, 1'b0, 3'b011};
    alu_tbl[7] = '{T_SLL,   1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
    alu_tbl[8] = '{T_SLTI,  1'b0, 1'b0, 1'b1, 1'b1, 3'b110};

    br_tbl[0] = '{T_BEQ,  1'b1, 1'b0, 2'b01};
    br_tbl[1] = '{T_BEQ,  1'b0, 1'b0, 2'b00};
    br_tbl[2] = '{T_BEQ,  1'b0, 1'b1, 2'b00};
    br_tbl[3] = '{T_BNE,  1'b0, 1'b0, 2'b01};
    br_tbl[4] = '{T_BNE,  1'b1, 1'b1, 2'b00};
    br_tbl[5] = '{T_BLTZ, 1'b0, 1'b1, 2'b01};
    br_tbl[6] = '{T_BLTZ, 1'b1, 1'b0, 2'b00};
    br_tbl[7] = '{T_BLTZ, 1'b0, 1'b0, 2'b00};

    for (int i = 0; i < 9; i++) op_list[i] = alu_tbl[i].op;
    op_list[9]  = T_SW;
    op_list[10] = T_LW;
    op_list[11] = T_BEQ;
    op_list[12] = T_BNE;
    op_list[13] = T_BLTZ;
    op_list[14] = T_J;

    Reset = 1'b0; Opcode = '0; zero = 1'b0; sign = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    last_pc_src = '0;
    do_reset();

    // Zero-wait add straight out of reset.
    run_instr(T_ADD, 0, 0, 1'b0, 1'b0, 0);

    // ALU decode vectors.
    for (int i = 0; i < 9; i++)
      run_instr(alu_tbl[i].op, i % 2, 0, 1'($urandom), 1'($urandom), 0);

    // Branch decision vectors.
    for (int i = 0; i < 8; i++) begin
      run_instr(br_tbl[i].op, 0, 0, br_tbl[i].z, br_tbl[i].s, 0);
      check($sformatf("branch pcsrc vec%0d", i), 64'(last_pc_src),
            64'(br_tbl[i].exp_pc_src));
    end

    // Jump, store, load without waits; load with three data waits.
    run_instr(T_J, 0, 0, 1'b0, 1'b0, 0);
    run_instr(T_SW, 0, 0, 1'b0, 1'b0, 0);
    run_instr(T_LW, 0, 0, 1'b0, 1'b0, 0);
    run_instr(T_LW, 0, 3, 1'b0, 1'b0, 0);

    // Ready on the last permitted wait cycle completes the access.
    run_instr(T_SW, WAIT_MAX - 1, WAIT_MAX - 1, 1'b0, 1'b0, 0);

    // Fetch timeout, data timeout, illegal opcode, halt.
    run_instr(T_ADD, WAIT_MAX, 0, 1'b0, 1'b0, 0);
    run_instr(T_LW, 1, WAIT_MAX, 1'b0, 1'b0, 0);
    run_instr(6'b101010, 0, 0, 1'b0, 1'b0, 0);
    run_instr(T_HALT, 2, 0, 1'b0, 1'b0, 0);

    // Reset asserted while a load waits in the memory state.
    run_instr(T_ORI, 0, 0, 1'b0, 1'b0, 0);
    run_instr(T_LW, 0, 3, 1'b0, 1'b0, 4);
    dmem_ready = 1'b0;
    Reset      = 1'b0;
    @(negedge CLK);
    check("mid-mem reset dmem_req", 64'(dmem_req), 64'd0);
    check("mid-mem reset nRD", 64'(nRD), 64'd1);
    @(posedge CLK);
    #1;
    check("mid-mem reset retired", 64'(retired), 64'd0);
    check("mid-mem reset cycles", 64'(cycles), 64'd0);
    Reset       = 1'b1;
    exp_retired = '0;
    exp_cycles  = '0;
    run_instr(T_ADD, 0, 0, 1'b0, 1'b0, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      int         r, iw, dw;
      logic [5:0] op;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        op = T_HALT;
      end else if (r < 6) begin
        op = 6'($urandom);
        while (is_defined(op)) op = 6'($urandom);
      end else begin
        op = op_list[$urandom_range(0, 14)];
      end
      iw = ($urandom_range(0, 29) == 0) ? WAIT_MAX : $urandom_range(0, 3);
      dw = ($urandom_range(0, 19) == 0) ? WAIT_MAX : $urandom_range(0, 3);
      run_instr(op, iw, dw, 1'($urandom), 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
